bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//  Downstream consumer of a chain of cascaded HC74160 decade counters.
//  - Captures the parallel BCD digits and the last stage's carry (C) into a shadow register on a LATCH strobe.
//  - Time-multiplexes the shadow register onto one shared 7-segment bus with a rotating digit select.
//  - Used in the frequency-meter / counter-display path, between the counter chain and the board display.
// PARAMETERS
//  DIGITS    4     number of BCD digits scanned (1..8); digit 0 = least significant
//  SCAN_DIV  1000  CLK cycles each digit stays selected (>=2)
//  DIV_W     10    prescaler width; must satisfy 2**DIV_W >= SCAN_DIV
// PORTS
//  CLK   in   1         system clock, rising-edge active
//  _RD   in   1         asynchronous active-low reset
//  BCD   in   4*DIGITS  counter outputs, digit i = BCD[4*i+3:4*i]
//  LATCH in   1         capture strobe, sampled high on a CLK rising edge
//  CY    in   1         carry (C) of the most significant counter stage
//  SEG   out  7         segments {g,f,e,d,c,b,a}, active-high
//  AN    out  DIGITS    digit select, active-low, one-hot-zero
//  OVF   out  1         overflow seen during the last capture window
// BEHAVIOUR
//  Reset (_RD=0, async, overrides everything):
//   - prescaler=0, idx=0, shadow=0, ovf_acc=0.
//   - SEG=7'h00, AN=all 1s (display dark), OVF=0.
//  Prescaler:
//   - Counts 0..SCAN_DIV-1 on every CLK edge.
//   - At terminal count it wraps to 0 and idx advances: idx=DIGITS-1 wraps to 0.
//  Capture:
//   - Edge with LATCH=1: shadow<=BCD, OVF<=ovf_acc|CY, ovf_acc<=0.
//   - Otherwise ovf_acc<=ovf_acc|CY (sticky).
//   - LATCH held high captures on every edge; no edge detection.
//   - LATCH=1 and CY=1 on the same edge: OVF=1, ovf_acc=0.
//  Output stage:
//   - SEG and AN are registered every edge from the current idx and shadow.
//   - AN[idx]=0, others 1.
//   - Latency: idx change -> AN/SEG on the next edge. LATCH edge k -> new value on SEG at edge k+1 (when that digit is selected).
//   - First edge after reset release: AN=~1 (digit 0), SEG=7'h3F.
//  Decode:
//   - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//   - Codes 10..15 show dash 7'h40.
//  Scan and capture are independent: a capture mid-scan does not reset idx or the prescaler.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN
//   - Defined: a digit i>0 is blanked (SEG=7'h00, AN still driven normally) when shadow digits i..DIGITS-1 are all 0. Digit 0 is never blanked; invalid codes count as nonzero.
//   - Undefined: every digit is always decoded.
// TESTING (DIGITS=4, SCAN_DIV=4)
//  1. Hold _RD=0 -> SEG=00, AN=F, OVF=0. Release -> AN sequence E,D,B,7,E..., 4 cycles per digit.
//  2. BCD=16'h1234, LATCH pulse -> digits 0..3 show 66,4F,5B,06; OVF=0.
//  3. BCD=16'h00A5, LATCH -> digit0=6D, digit1=40. Digits 2,3: 3F without the macro, 00 with LEADING_ZERO_BLANK_EN.
//  4. Pulse CY once mid-window, then LATCH -> OVF=1. Next LATCH with no CY -> OVF=0.
//  5. CY=1 and LATCH=1 same edge -> OVF=1; following LATCH without CY -> OVF=0.
//  6. Assert _RD mid-scan (idx=2, between clocks) -> outputs reset immediately, no CLK edge needed. Release -> scan restarts at digit 0.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// Shadow-latches a cascaded BCD counter chain and scans it onto one 7-segment bus.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_display_scanner #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DIV_W    = 10
) (
  input  logic                CLK,
  input  logic                _RD,
  input  logic [4*DIGITS-1:0] BCD,
  input  logic                LATCH,
  input  logic                CY,
  output logic [6:0]          SEG,
  output logic [DIGITS-1:0]   AN,
  output logic                OVF
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] PRESC_TERM = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow;
  logic                ovf_acc;
  logic [3:0]          cur_digit;
  logic [DIGITS-1:0]   blank;
  logic [6:0]          seg_next;
  logic [DIGITS-1:0]   an_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  // Scan timebase: idx steps once per SCAN_DIV clocks, independent of capture.
  always_ff @(posedge CLK or negedge _RD) begin
    if (!_RD) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRESC_TERM) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Carry is sticky across the window and handed to OVF on each capture.
  always_ff @(posedge CLK or negedge _RD) begin
    if (!_RD) begin
      shadow  <= '0;
      ovf_acc <= 1'b0;
      OVF     <= 1'b0;
    end else if (LATCH) begin
      shadow  <= BCD;
      OVF     <= ovf_acc | CY;
      ovf_acc <= 1'b0;
    end else begin
      ovf_acc <= ovf_acc | CY;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit is blank while everything above and including it is zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above & (shadow[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    cur_digit    = shadow[4*idx +: 4];
    seg_next     = blank[idx] ? 7'h00 : seg_decode(cur_digit);
    an_next      = '1;
    an_next[idx] = 1'b0;
  end

  always_ff @(posedge CLK or negedge _RD) begin
    if (!_RD) begin
      SEG <= 7'h00;
      AN  <= '1;
    end else begin
      SEG <= seg_next;
      AN  <= an_next;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner (DIGITS=4, SCAN_DIV=4): directed display checks plus a
// cycle scoreboard of {AN,SEG,OVF}. Define LEADING_ZERO_BLANK_EN to test the blanking build.
module tb_bcd_display_scanner;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rd_n = 1'b0;
  logic [15:0] bcd = '0;
  logic        latch = 1'b0;
  logic        cy = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        ovf;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [11:0] exp_q[$];

  bcd_display_scanner #(.DIGITS(DIGITS), .SCAN_DIV(4), .DIV_W(2)) dut (
    .CLK(clk), ._RD(rd_n), .BCD(bcd), .LATCH(latch), .CY(cy),
    .SEG(seg), .AN(an), .OVF(ovf)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else pass_cnt++;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [0:9];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (d <= 4'd9) ? tbl[d] : 7'h40;
  endfunction

  function automatic logic [6:0] model_seg(input logic [15:0] sh, input int i);
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && (sh >> (4*i)) == 16'h0) return 7'h00;
`endif
    return seg_of(sh[4*i +: 4]);
  endfunction

  // ---------------- reference model / scoreboard ----------------
  int          m_presc = 0;
  int          m_idx = 0;
  logic [15:0] m_shadow = '0;
  logic        m_acc = 1'b0;
  logic        m_ovf = 1'b0;

  always @(posedge clk or negedge rd_n) begin
    logic [6:0] e_seg;
    logic [3:0] e_an;
    if (!rd_n) begin
      m_presc = 0; m_idx = 0; m_shadow = '0; m_acc = 1'b0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      e_seg = model_seg(m_shadow, m_idx);
      e_an  = 4'hF & ~(4'b0001 << m_idx);
      if (latch) begin
        m_ovf = m_acc | cy;
        m_acc = 1'b0;
        m_shadow = bcd;
      end else begin
        m_acc = m_acc | cy;
      end
      m_presc = m_presc + 1;
      if (m_presc == 4) begin
        m_presc = 0;
        m_idx = (m_idx + 1) % DIGITS;
      end
      exp_q.push_back({e_an, e_seg, m_ovf});
    end
  end

  always @(negedge clk) begin
    logic [11:0] e;
    if (rd_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("sb_an", 32'(an), 32'(e[11:8]));
      check_eq("sb_seg", 32'(seg), 32'(e[7:1]));
      check_eq("sb_ovf", 32'(ovf), 32'(e[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic latch_value(input logic [15:0] v, input logic c);
    @(negedge clk);
    bcd = v; latch = 1'b1; cy = c;
    @(negedge clk);
    latch = 1'b0; cy = 1'b0;
    @(negedge clk);
  endtask

  task automatic show_digit(input int i, input logic [6:0] exp_seg, input string tag);
    logic [3:0] target;
    bit found;
    target = 4'hF & ~(4'b0001 << i);
    found = 1'b0;
    for (int n = 0; n < 24 && !found; n++) begin
      if (an == target) found = 1'b1;
      else @(negedge clk);
    end
    if (found) check_eq(tag, 32'(seg), 32'(exp_seg));
    else check_eq({tag, "_tmo"}, 32'(an), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] dig23;
`ifdef LEADING_ZERO_BLANK_EN
    dig23 = 4'h0;
`else
    dig23 = 4'h1;
`endif
    // 1: reset hold and scan order
    repeat (3) @(negedge clk);
    check_eq("rst_seg", 32'(seg), 32'h00);
    check_eq("rst_an", 32'(an), 32'hF);
    check_eq("rst_ovf", 32'(ovf), 32'h0);
    rd_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check_eq("scan_an", 32'(an), 32'(4'hF & ~(4'b0001 << ((n / 4) % 4))));
      if (n == 0) check_eq("first_seg", 32'(seg), 32'h3F);
    end

    // 2: plain digits
    latch_value(16'h1234, 1'b0);
    check_eq("ovf_clean", 32'(ovf), 32'h0);
    show_digit(0, 7'h66, "d0_1234");
    show_digit(1, 7'h4F, "d1_1234");
    show_digit(2, 7'h5B, "d2_1234");
    show_digit(3, 7'h06, "d3_1234");

    // 3: invalid code and leading zeros
    latch_value(16'h00A5, 1'b0);
    show_digit(0, 7'h6D, "d0_00a5");
    show_digit(1, 7'h40, "d1_00a5");
    show_digit(2, dig23 != 0 ? 7'h3F : 7'h00, "d2_00a5");
    show_digit(3, dig23 != 0 ? 7'h3F : 7'h00, "d3_00a5");

    // 4: sticky carry inside the window
    repeat (2) @(negedge clk);
    cy = 1'b1;
    @(negedge clk);
    cy = 1'b0;
    repeat (3) @(negedge clk);
    latch_value(16'h0007, 1'b0);
    check_eq("ovf_sticky", 32'(ovf), 32'h1);
    latch_value(16'h0008, 1'b0);
    check_eq("ovf_cleared", 32'(ovf), 32'h0);
    show_digit(0, 7'h7F, "d0_0008");

    // 5: carry on the capture edge itself
    latch_value(16'h9999, 1'b1);
    check_eq("ovf_same_edge", 32'(ovf), 32'h1);
    latch_value(16'h9999, 1'b0);
    check_eq("ovf_after_same", 32'(ovf), 32'h0);
    show_digit(3, 7'h6F, "d3_9999");

    // random traffic, scoreboard only
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bcd   = 16'($urandom);
      latch = ($urandom_range(0, 5) == 0);
      cy    = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    latch = 1'b0; cy = 1'b0;

    // 6: asynchronous reset mid-scan
    show_digit(2, model_seg(m_shadow, 2), "d2_prerst");
    #2;
    rd_n = 1'b0;
    #1;
    check_eq("arst_seg", 32'(seg), 32'h00);
    check_eq("arst_an", 32'(an), 32'hF);
    check_eq("arst_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    rd_n = 1'b1;
    @(negedge clk);
    check_eq("restart_an", 32'(an), 32'hE);
    check_eq("restart_seg", 32'(seg), 32'h3F);
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
